branch_predictor_gshare_spec: RTL and testbench

- Parametrised gshare branch predictor: global history (GHR) XOR PC indexes a table of saturating counters.
- Sits behind branch_controller. It predicts at decode and is trained from EX feedback.
- History is updated speculatively at prediction time. An in-flight FIFO holds each branch's table index, GHR snapshot and prediction.
- On a mispredict or squash, history is repaired exactly. Training always updates the entry that made the prediction.
- A reset-sweep FSM initialises the table, so no table flops need async reset.

---
 rtl/branch_predictor_gshare_spec.sv | 223 ++++++++++++++++++++++
 tb/tb_branch_predictor_gshare_spec.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_gshare_spec.sv
// Gshare branch predictor: GHR XOR PC indexes a table of saturating counters, with
// speculative history, exact repair from an in-flight FIFO, and a reset-sweep table init.
// Optional statistics counters are built when the BP_STATS_EN macro is defined.

module branch_predictor_gshare_spec_chk (
  input logic clk,
  input logic rst_n,
  input logic run,
  input logic fb_valid,
  input logic fifo_empty
);
  // Feedback while nothing is in flight indicates an upstream sequencing bug.
  a_fb_without_inflight: assert property (@(posedge clk) disable iff (!rst_n)
    !(run && fb_valid && fifo_empty))
    else $error("feedback received with no in-flight branch");
endmodule

module branch_predictor_gshare_spec #(
  parameter int ADDR_WIDTH  = 32,
  parameter int TABLE_DEPTH = 1024,
  parameter int HIST_LEN    = 10,
  parameter int CTR_BITS    = 2,
  parameter int INFLIGHT    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req_valid,
  input  logic [ADDR_WIDTH-1:0] i_req_pc,
  output logic                  o_req_ready,
  output logic                  o_req_prediction,
  input  logic                  i_fb_valid,
  input  logic                  i_fb_outcome,
  output logic                  o_fb_mispredict,
  input  logic                  i_squash,
  output logic [31:0]           o_stat_branches,
  output logic [31:0]           o_stat_mispredicts
);
  localparam int IDX   = $clog2(TABLE_DEPTH);
  localparam int PTR_W = $clog2(INFLIGHT);
  localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX = {CTR_BITS{1'b1}};
  localparam logic [IDX-1:0]      SWEEP_LAST = IDX'(TABLE_DEPTH - 1);
  localparam logic [PTR_W:0]      CNT_FULL = (PTR_W + 1)'(INFLIGHT);

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

  function automatic logic [HIST_LEN-1:0] ghr_shift(input logic [HIST_LEN-1:0] g, input logic b);
    logic [HIST_LEN-1:0] r;
    r    = g << 1;
    r[0] = b;
    return r;
  endfunction

  function automatic logic [CTR_BITS-1:0] ctr_train(input logic [CTR_BITS-1:0] c, input logic taken);
    logic [CTR_BITS-1:0] r;
    r = c;
    if (taken && (c != CTR_MAX)) r = c + CTR_BITS'(1);
    else if (!taken && (c != {CTR_BITS{1'b0}})) r = c - CTR_BITS'(1);
    else r = c;
    return r;
  endfunction

  state_e               state_r, state_nxt_s;
  logic                 run_s;
  logic [IDX-1:0]       sweep_r;
  logic [HIST_LEN-1:0]  ghr_r, ghr_nxt_s;
  logic [CTR_BITS-1:0]  table_r [TABLE_DEPTH];
  logic [IDX-1:0]       fifo_idx_r  [INFLIGHT];
  logic [HIST_LEN-1:0]  fifo_ghr_r  [INFLIGHT];
  logic                 fifo_pred_r [INFLIGHT];
  logic [PTR_W-1:0]     rd_ptr_r, wr_ptr_r;
  logic [PTR_W:0]       count_r;

  logic [IDX-1:0]       req_idx_s, head_idx_s;
  logic [HIST_LEN-1:0]  head_ghr_s;
  logic                 head_pred_s, pred_s, ready_s;
  logic                 fb_act_s, mispredict_s, squash_s, accept_s, flush_s;
  logic [CTR_BITS-1:0]  ctr_next_s;
  logic                 unused_pc_s;

  assign unused_pc_s = ^{i_req_pc[ADDR_WIDTH-1:IDX+2], i_req_pc[1:0]};

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_INIT;
    else        state_r <= state_nxt_s;
  end

  // FSM next state: leave INIT once the last entry has been written.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_INIT: begin
        if (sweep_r == SWEEP_LAST) state_nxt_s = ST_RUN;
        else                       state_nxt_s = ST_INIT;
      end
      ST_RUN:  state_nxt_s = ST_RUN;
      default: state_nxt_s = ST_INIT;
    endcase
  end

  // FSM outputs.
  always_comb begin
    run_s = 1'b0;
    case (state_r)
      ST_INIT: run_s = 1'b0;
      ST_RUN:  run_s = 1'b1;
      default: run_s = 1'b0;
    endcase
  end

  // Sweep pointer walks the table during INIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      sweep_r <= {IDX{1'b0}};
    else if (!run_s) sweep_r <= sweep_r + IDX'(1);
    else             sweep_r <= sweep_r;
  end

  assign head_idx_s  = fifo_idx_r[rd_ptr_r];
  assign head_ghr_s  = fifo_ghr_r[rd_ptr_r];
  assign head_pred_s = fifo_pred_r[rd_ptr_r];
  assign req_idx_s   = i_req_pc[IDX+1:2] ^ IDX'(ghr_r);
  assign ctr_next_s  = ctr_train(table_r[head_idx_s], i_fb_outcome);

  // Request/feedback decode; the table read sees pre-write contents.
  always_comb begin
    fb_act_s     = run_s && i_fb_valid && (count_r != {(PTR_W+1){1'b0}});
    mispredict_s = fb_act_s && (i_fb_outcome != head_pred_s);
    squash_s     = run_s && i_squash;
    flush_s      = mispredict_s || squash_s;
    pred_s       = run_s ? table_r[req_idx_s][CTR_BITS-1] : 1'b0;
    ready_s      = run_s && ((count_r < CNT_FULL) ||
                   ((count_r == CNT_FULL) && fb_act_s && !mispredict_s));
    accept_s     = i_req_valid && ready_s && !flush_s;
  end

  // History repair: resolved outcome on top of the head's snapshot wins over speculation.
  always_comb begin
    ghr_nxt_s = ghr_r;
    if (fb_act_s && flush_s)                           ghr_nxt_s = ghr_shift(head_ghr_s, i_fb_outcome);
    else if (squash_s && (count_r != {(PTR_W+1){1'b0}})) ghr_nxt_s = head_ghr_s;
    else if (accept_s)                                 ghr_nxt_s = ghr_shift(ghr_r, pred_s);
    else                                               ghr_nxt_s = ghr_r;
  end

  // Speculative global history register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ghr_r <= {HIST_LEN{1'b0}};
    else        ghr_r <= ghr_nxt_s;
  end

  // In-flight FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {(PTR_W+1){1'b0}};
    end else if (flush_s) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {(PTR_W+1){1'b0}};
    end else begin
      rd_ptr_r <= rd_ptr_r + PTR_W'(fb_act_s);
      wr_ptr_r <= wr_ptr_r + PTR_W'(accept_s);
      count_r  <= count_r + (PTR_W+1)'(accept_s) - (PTR_W+1)'(fb_act_s);
    end
  end

  // In-flight FIFO payload; no reset needed since occupancy guards every read.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      fifo_idx_r[wr_ptr_r]  <= req_idx_s;
      fifo_ghr_r[wr_ptr_r]  <= ghr_r;
      fifo_pred_r[wr_ptr_r] <= pred_s;
    end else begin
      fifo_idx_r[wr_ptr_r]  <= fifo_idx_r[wr_ptr_r];
      fifo_ghr_r[wr_ptr_r]  <= fifo_ghr_r[wr_ptr_r];
      fifo_pred_r[wr_ptr_r] <= fifo_pred_r[wr_ptr_r];
    end
  end

  // Counter table: init sweep in INIT, training of the predicting entry in RUN.
  always_ff @(posedge clk) begin
    if (!run_s)        table_r[sweep_r]    <= CTR_WNT;
    else if (fb_act_s) table_r[head_idx_s] <= ctr_next_s;
    else               table_r[head_idx_s] <= table_r[head_idx_s];
  end

  assign o_req_ready      = ready_s;
  assign o_req_prediction = pred_s;
  assign o_fb_mispredict  = mispredict_s;

`ifdef BP_STATS_EN
  logic [31:0] stat_br_r, stat_mp_r;

  // Saturating feedback and mispredict counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_br_r <= 32'd0;
      stat_mp_r <= 32'd0;
    end else begin
      if (fb_act_s && (stat_br_r != 32'hFFFF_FFFF))     stat_br_r <= stat_br_r + 32'd1;
      else                                             stat_br_r <= stat_br_r;
      if (mispredict_s && (stat_mp_r != 32'hFFFF_FFFF)) stat_mp_r <= stat_mp_r + 32'd1;
      else                                             stat_mp_r <= stat_mp_r;
    end
  end

  assign o_stat_branches    = stat_br_r;
  assign o_stat_mispredicts = stat_mp_r;
`else
  assign o_stat_branches    = 32'd0;
  assign o_stat_mispredicts = 32'd0;
`endif

  branch_predictor_gshare_spec_chk u_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run_s),
    .fb_valid   (i_fb_valid),
    .fifo_empty (count_r == {(PTR_W+1){1'b0}})
  );
endmodule

// File: tb/tb_branch_predictor_gshare_spec.sv
// Self-checking bench for branch_predictor_gshare_spec: directed vector table, hand
// sequences for full-FIFO and reset, and randomized traffic against a behavioural model.
module tb_branch_predictor_gshare_spec;
  localparam int DEPTH = 16;
  localparam int HIST  = 4;
  localparam int CBITS = 2;
  localparam int INFL  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_pc = 32'd0;
  logic        req_ready, req_pred;
  logic        fb_valid = 1'b0, fb_outcome = 1'b0, squash = 1'b0;
  logic        fb_mis;
  logic [31:0] stat_br, stat_mp;

  branch_predictor_gshare_spec #(
    .ADDR_WIDTH(32), .TABLE_DEPTH(DEPTH), .HIST_LEN(HIST), .CTR_BITS(CBITS), .INFLIGHT(INFL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(req_valid), .i_req_pc(req_pc), .o_req_ready(req_ready),
    .o_req_prediction(req_pred),
    .i_fb_valid(fb_valid), .i_fb_outcome(fb_outcome), .o_fb_mispredict(fb_mis),
    .i_squash(squash), .o_stat_branches(stat_br), .o_stat_mispredicts(stat_mp)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  // Behavioural model: counters as integers, history as an integer, in-flight list as a queue.
  typedef struct { int idx; int ghr; bit pred; } rec_t;
  int   ctr_m [DEPTH];
  int   ghr_m;
  rec_t q_m [$];
  int   stat_b_m, stat_m_m;

  function automatic int hist_push(input int g, input bit b);
    return ((g * 2) + int'(b)) % (1 << HIST);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) ctr_m[i] = (1 << (CBITS - 1)) - 1;
    ghr_m = 0;
    q_m.delete();
    stat_b_m = 0;
    stat_m_m = 0;
  endtask

  task automatic step(input bit rv, input logic [31:0] pc, input bit fv, input bit oc, input bit sq,
                      output bit ob_r, output bit ob_p, output bit ob_m);
    int   idx;
    bit   e_r, e_p, e_m, hv;
    rec_t h;
    @(negedge clk);
    req_valid = rv; req_pc = pc; fb_valid = fv; fb_outcome = oc; squash = sq;
    idx = (int'(pc >> 2) % DEPTH) ^ ghr_m;
    e_p = (ctr_m[idx] >= (1 << (CBITS - 1)));
    hv  = (q_m.size() > 0);
    if (hv) h = q_m[0];
    e_m = fv && hv && (oc != h.pred);
    e_r = (q_m.size() < INFL) || ((q_m.size() == INFL) && fv && !e_m);
    #1;
    ob_r = req_ready; ob_p = req_pred; ob_m = fb_mis;
    chk("ready", {31'd0, req_ready}, {31'd0, e_r});
    chk("prediction", {31'd0, req_pred}, {31'd0, e_p});
    chk("mispredict", {31'd0, fb_mis}, {31'd0, e_m});
    @(posedge clk);
    if (fv && hv) begin
      if (oc) ctr_m[h.idx] = (ctr_m[h.idx] < (1 << CBITS) - 1) ? ctr_m[h.idx] + 1 : ctr_m[h.idx];
      else    ctr_m[h.idx] = (ctr_m[h.idx] > 0) ? ctr_m[h.idx] - 1 : 0;
      void'(q_m.pop_front());
      stat_b_m++;
      if (e_m) stat_m_m++;
    end
    if (fv && hv && (e_m || sq)) begin
      ghr_m = hist_push(h.ghr, oc);
      q_m.delete();
    end else if (sq) begin
      if (hv) ghr_m = h.ghr;
      q_m.delete();
    end else if (rv && e_r) begin
      q_m.push_back('{idx: idx, ghr: ghr_m, pred: e_p});
      ghr_m = hist_push(ghr_m, e_p);
    end
  endtask

  // Release reset and check that ready stays low for exactly DEPTH cycles, ignoring traffic.
  task automatic release_and_init();
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      req_valid = 1'b1; req_pc = 32'h40; fb_valid = 1'b1; fb_outcome = 1'b1; squash = i[0];
      #1;
      chk("init_ready", {31'd0, req_ready}, 32'd0);
      chk("init_pred", {31'd0, req_pred}, 32'd0);
      @(posedge clk);
    end
  endtask

  typedef struct {
    bit rv; logic [31:0] pc; bit fv; bit oc; bit sq;
    bit e_ready; bit e_pred; bit e_mis;
  } vec_t;
  vec_t vecs [11];

  task automatic chk_stats(input string tag);
`ifdef BP_STATS_EN
    chk({tag, "_stat_branches"}, stat_br, stat_b_m);
    chk({tag, "_stat_mispredicts"}, stat_mp, stat_m_m);
`else
    chk({tag, "_stat_branches"}, stat_br, 32'd0);
    chk({tag, "_stat_mispredicts"}, stat_mp, 32'd0);
`endif
  endtask

  task automatic random_run(input int n);
    bit r, p, m, fv, oc;
    for (int i = 0; i < n; i++) begin
      fv = (q_m.size() > 0) && ($urandom_range(0, 2) == 0);
      if (q_m.size() > 0 && $urandom_range(0, 3) != 0) oc = q_m[0].pred;
      else                                             oc = 1'($urandom_range(0, 1));
      step(($urandom_range(0, 4) != 0), $urandom, fv, oc, ($urandom_range(0, 19) == 0), r, p, m);
    end
  endtask

  initial begin
    bit r, p, m;
    // {rv, pc, fv, oc, sq, ready, pred, mispredict}, all counters weak-not-taken, GHR=0.
    vecs[0]  = '{1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 32'h40, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 32'h44, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 32'h44, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 32'h4C, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 32'h4C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 32'h40, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 32'h70, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 32'h70, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_pred", {31'd0, req_pred}, 32'd0);
    chk("rst_mispredict", {31'd0, fb_mis}, 32'd0);
    chk("rst_stat_branches", stat_br, 32'd0);
    chk("rst_stat_mispredicts", stat_mp, 32'd0);
    release_and_init();

    for (int i = 0; i < 11; i++) begin
      step(vecs[i].rv, vecs[i].pc, vecs[i].fv, vecs[i].oc, vecs[i].sq, r, p, m);
      chk($sformatf("vec%0d_ready", i), {31'd0, r}, {31'd0, vecs[i].e_ready});
      chk($sformatf("vec%0d_pred", i), {31'd0, p}, {31'd0, vecs[i].e_pred});
      chk($sformatf("vec%0d_mis", i), {31'd0, m}, {31'd0, vecs[i].e_mis});
    end

    // Fill the FIFO, then a correct feedback lets a held request in while staying full.
    for (int i = 0; i < 4; i++) step(1'b1, 32'h40, 1'b0, 1'b0, 1'b0, r, p, m);
    step(1'b1, 32'h40, 1'b0, 1'b0, 1'b0, r, p, m);
    chk("full_ready_low", {31'd0, r}, 32'd0);
    step(1'b1, 32'h40, 1'b1, q_m[0].pred, 1'b0, r, p, m);
    chk("full_pop_push_ready", {31'd0, r}, 32'd1);
    step(1'b1, 32'h40, 1'b0, 1'b0, 1'b0, r, p, m);
    chk("full_still_full", {31'd0, r}, 32'd0);

    // Squash with entries in flight, then speculate again and mispredict with a same-cycle request.
    step(1'b0, 32'h40, 1'b0, 1'b0, 1'b1, r, p, m);
    for (int i = 0; i < 3; i++) step(1'b1, 32'h48, 1'b0, 1'b0, 1'b0, r, p, m);
    step(1'b1, 32'h48, 1'b1, ~q_m[0].pred, 1'b0, r, p, m);
    chk("spec_mispredict", {31'd0, m}, 32'd1);
    step(1'b1, 32'h48, 1'b0, 1'b0, 1'b0, r, p, m);

    random_run(3000);
    chk_stats("run1");

    // Asynchronous reset in the middle of a cycle.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ready", {31'd0, req_ready}, 32'd0);
    chk("midrst_pred", {31'd0, req_pred}, 32'd0);
    chk("midrst_stat_branches", stat_br, 32'd0);
    chk("midrst_stat_mispredicts", stat_mp, 32'd0);
    repeat (2) @(posedge clk);
    release_and_init();
    random_run(800);
    chk_stats("run2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
